// File: rtl/cpu_defs.sv
// Shared definitions for the RV32 control path: FSM state encodings,
// instruction classes, opcode/funct constants and datapath mux select codes.
package cpu_defs;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        EXEC_M   = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        JALR     = 4'd12,
        HALT     = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU_R,
        CLS_MUL,
        CLS_ALU_I,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_NONE
    } iclass_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] WB_MUL    = 2'b11;

    // States that sit on the memory handshake and are subject to the timeout.
    function automatic logic is_mem_wait(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      iInstruction;
    logic             iMemReady;
    logic             iMulDone;
    logic             iZero;
    logic             oPCWrite;
    logic             oPCWriteCond;
    logic             oIorD;
    logic             oIRWrite;
    logic             oMemRead;
    logic             oMemWrite;
    logic             oRegWrite;
    logic             oMulStart;
    logic [1:0]       oALUSrcA;
    logic [1:0]       oALUSrcB;
    logic [1:0]       oALUOp;
    logic [1:0]       oPCSource;
    logic [1:0]       oMemtoReg;
    logic [3:0]       oState;
    logic [CNT_W-1:0] oInstret;
    logic             oFault;

    modport master (
        input  iInstruction, iMemReady, iMulDone, iZero,
        output oPCWrite, oPCWriteCond, oIorD, oIRWrite, oMemRead, oMemWrite,
               oRegWrite, oMulStart, oALUSrcA, oALUSrcB, oALUOp, oPCSource,
               oMemtoReg, oState, oInstret, oFault
    );

    modport slave (
        output iInstruction, iMemReady, iMulDone, iZero,
        input  oPCWrite, oPCWriteCond, oIorD, oIRWrite, oMemRead, oMemWrite,
               oRegWrite, oMulStart, oALUSrcA, oALUSrcB, oALUOp, oPCSource,
               oMemtoReg, oState, oInstret, oFault
    );
endinterface

// File: rtl/instr_classify.sv
// Opcode/funct legality decode: maps an instruction onto the class that
// selects the execute path, flagging everything unsupported as illegal.
module instr_classify
    import cpu_defs::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output iclass_t    iclass,
    output logic       illegal
);

    // Class decode; anything not matched stays CLS_NONE.
    always_comb begin
        iclass = CLS_NONE;
        case (opcode)
            OP_LOAD:  iclass = CLS_LOAD;
            OP_STORE: iclass = CLS_STORE;
            OP_RTYPE: begin
                if (funct7 == F7_BASE &&
                    (funct3 == F3_ADD || funct3 == F3_SLT ||
                     funct3 == F3_OR  || funct3 == F3_AND))
                    iclass = CLS_ALU_R;
                else if (funct7 == F7_ALT && funct3 == F3_ADD)
                    iclass = CLS_ALU_R;
                else if (ENABLE_M != 0 && funct7 == F7_MULDIV)
                    iclass = CLS_MUL;
            end
            OP_ITYPE:  iclass = CLS_ALU_I;
            OP_BRANCH: if (funct3 == F3_BEQ) iclass = CLS_BRANCH;
            OP_JAL:    iclass = CLS_JAL;
            OP_JALR:   iclass = CLS_JALR;
            default:   iclass = CLS_NONE;
        endcase
    end

    assign illegal = (iclass == CLS_NONE);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 controller: FSM sequencing fetch/decode/execute/write-back,
// memory-wait timeout, sticky fault and retired-instruction counter.
module multicycle_control
    import cpu_defs::*;
#(
    parameter int ENABLE_M    = 0,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                 iCLK,
    input logic                 iRST_n,
    multicycle_control_if.master bus
);

    // Wait counter only needs to reach MEM_TIMEOUT-1: that is the last cycle
    // in which a missing ready forces the HALT transition.
    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

    state_t         state;
    state_t         state_next;
    logic [TW-1:0]  wait_cnt;
    logic [CNT_W-1:0] instret;
    logic           fault;
    logic           mul_issued;
    logic           retire;
    iclass_t        iclass;
    logic           illegal;
    logic           mem_timeout;
    logic           unused_inputs;

    // Register fields and branch-condition flag are consumed by the datapath.
    assign unused_inputs = ^{bus.iZero, bus.iInstruction[24:15], bus.iInstruction[11:7]};

    instr_classify #(
        .ENABLE_M(ENABLE_M)
    ) u_classify (
        .opcode (bus.iInstruction[6:0]),
        .funct3 (bus.iInstruction[14:12]),
        .funct7 (bus.iInstruction[31:25]),
        .iclass (iclass),
        .illegal(illegal)
    );

    assign mem_timeout = (wait_cnt == WAIT_LAST);

    // State, wait counter, retire counter, sticky fault and multiply-issued flag.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            instret    <= '0;
            fault      <= 1'b0;
            mul_issued <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (is_mem_wait(state))
                wait_cnt <= wait_cnt + TW'(1);
            if (retire)
                instret <= instret + CNT_W'(1);
            if (state_next == HALT)
                fault <= 1'b1;
            mul_issued <= (state == EXEC_M) && (state_next == EXEC_M);
        end
    end

    // Next-state and datapath strobes from the current state and handshakes.
    always_comb begin
        state_next       = state;
        retire           = 1'b0;
        bus.oPCWrite     = 1'b0;
        bus.oPCWriteCond = 1'b0;
        bus.oIorD        = 1'b0;
        bus.oIRWrite     = 1'b0;
        bus.oMemRead     = 1'b0;
        bus.oMemWrite    = 1'b0;
        bus.oRegWrite    = 1'b0;
        bus.oMulStart    = 1'b0;
        bus.oALUSrcA     = SRCA_PC;
        bus.oALUSrcB     = SRCB_RS2;
        bus.oALUOp       = ALUOP_ADD;
        bus.oPCSource    = PCSRC_ALU;
        bus.oMemtoReg    = WB_ALUOUT;
        case (state)
            FETCH: begin
                bus.oMemRead = 1'b1;
                bus.oALUSrcA = SRCA_PC;
                bus.oALUSrcB = SRCB_FOUR;
                if (bus.iMemReady) begin
                    bus.oIRWrite = 1'b1;
                    bus.oPCWrite = 1'b1;
                    state_next   = DECODE;
                end else if (mem_timeout) begin
                    state_next = HALT;
                end
            end
            DECODE: begin
                bus.oALUSrcA = SRCA_OLDPC;
                bus.oALUSrcB = SRCB_IMM;
                if (illegal) begin
                    state_next = HALT;
                end else begin
                    case (iclass)
                        CLS_LOAD, CLS_STORE: state_next = MEMADDR;
                        CLS_ALU_R:           state_next = EXEC_R;
                        CLS_MUL:             state_next = EXEC_M;
                        CLS_ALU_I:           state_next = EXEC_I;
                        CLS_BRANCH:          state_next = BRANCH;
                        CLS_JAL:             state_next = JAL;
                        CLS_JALR:            state_next = JALR;
                        default:             state_next = HALT;
                    endcase
                end
            end
            MEMADDR: begin
                bus.oALUSrcA = SRCA_RS1;
                bus.oALUSrcB = SRCB_IMM;
                state_next   = (iclass == CLS_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.oMemRead = 1'b1;
                bus.oIorD    = 1'b1;
                if (bus.iMemReady)
                    state_next = MEMWB;
                else if (mem_timeout)
                    state_next = HALT;
            end
            MEMWB: begin
                bus.oRegWrite = 1'b1;
                bus.oMemtoReg = WB_MDR;
                state_next    = FETCH;
                retire        = 1'b1;
            end
            MEMWRITE: begin
                bus.oMemWrite = 1'b1;
                bus.oIorD     = 1'b1;
                if (bus.iMemReady) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end else if (mem_timeout) begin
                    state_next = HALT;
                end
            end
            EXEC_R: begin
                bus.oALUSrcA = SRCA_RS1;
                bus.oALUSrcB = SRCB_RS2;
                bus.oALUOp   = ALUOP_FUNCT;
                state_next   = ALUWB;
            end
            EXEC_I: begin
                bus.oALUSrcA = SRCA_RS1;
                bus.oALUSrcB = SRCB_IMM;
                bus.oALUOp   = ALUOP_FUNCT;
                state_next   = ALUWB;
            end
            ALUWB: begin
                bus.oRegWrite = 1'b1;
                bus.oMemtoReg = WB_ALUOUT;
                state_next    = FETCH;
                retire        = 1'b1;
            end
            EXEC_M: begin
                bus.oMulStart = !mul_issued;
                if (bus.iMulDone) begin
                    bus.oRegWrite = 1'b1;
                    bus.oMemtoReg = WB_MUL;
                    state_next    = FETCH;
                    retire        = 1'b1;
                end
            end
            BRANCH: begin
                bus.oPCWriteCond = 1'b1;
                bus.oALUSrcA     = SRCA_RS1;
                bus.oALUSrcB     = SRCB_RS2;
                bus.oALUOp       = ALUOP_SUB;
                bus.oPCSource    = PCSRC_ALUOUT;
                state_next       = FETCH;
                retire           = 1'b1;
            end
            JAL, JALR: begin
                bus.oPCWrite  = 1'b1;
                bus.oPCSource = (state == JALR) ? PCSRC_JALR : PCSRC_ALUOUT;
                bus.oRegWrite = 1'b1;
                bus.oMemtoReg = WB_PC4;
                state_next    = FETCH;
                retire        = 1'b1;
            end
            HALT:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    assign bus.oState   = state;
    assign bus.oInstret = instret;
    assign bus.oFault   = fault;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: per-cycle expected
// states/strobes are queued with their stimulus, then replayed and compared.
module tb_multicycle_control;
    import cpu_defs::*;

    logic iCLK = 1'b0;
    logic iRST_n;

    always #5 iCLK = ~iCLK;

    multicycle_control_if #(.CNT_W(4))  bus_a ();
    multicycle_control_if #(.CNT_W(32)) bus_b ();

    multicycle_control #(.ENABLE_M(1), .CNT_W(4), .MEM_TIMEOUT(15)) dut_a (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .bus   (bus_a)
    );

    multicycle_control #(.ENABLE_M(0), .CNT_W(32), .MEM_TIMEOUT(15)) dut_b (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .bus   (bus_b)
    );

    assign bus_b.iInstruction = bus_a.iInstruction;
    assign bus_b.iMemReady    = bus_a.iMemReady;
    assign bus_b.iMulDone     = bus_a.iMulDone;
    assign bus_b.iZero        = bus_a.iZero;

    logic unused_b;
    assign unused_b = ^{bus_b.oPCWrite, bus_b.oPCWriteCond, bus_b.oIorD, bus_b.oIRWrite,
                        bus_b.oMemRead, bus_b.oMemWrite, bus_b.oRegWrite, bus_b.oMulStart,
                        bus_b.oALUSrcA, bus_b.oALUSrcB, bus_b.oALUOp, bus_b.oPCSource,
                        bus_b.oMemtoReg};

    typedef struct {
        string      tag;
        logic       rdy;
        logic       done;
        logic [3:0] st;
        logic [7:0] stb;
        logic [1:0] pcs;
        logic [1:0] m2r;
        logic       flt;
        logic       chk_sel;
        logic [5:0] sel;
    } vec_t;

    vec_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic rdy, input logic done, input state_t st,
                        input logic [7:0] stb, input logic [1:0] pcs, input logic [1:0] m2r,
                        input logic flt, input logic chk_sel, input logic [5:0] sel);
        vec_t v;
        v.tag = tag; v.rdy = rdy; v.done = done; v.st = st; v.stb = stb;
        v.pcs = pcs; v.m2r = m2r; v.flt = flt; v.chk_sel = chk_sel; v.sel = sel;
        q.push_back(v);
    endtask

    // Replay queued cycles: drive just after the rising edge, compare on the falling edge.
    task automatic run_queue();
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            bus_a.iMemReady = v.rdy;
            bus_a.iMulDone  = v.done;
            @(negedge iCLK);
            check({v.tag, "/state"}, 32'(bus_a.oState), 32'(v.st));
            check({v.tag, "/strobes"},
                  32'({bus_a.oPCWrite, bus_a.oPCWriteCond, bus_a.oIorD, bus_a.oIRWrite,
                       bus_a.oMemRead, bus_a.oMemWrite, bus_a.oRegWrite, bus_a.oMulStart}),
                  32'(v.stb));
            check({v.tag, "/pcsource"}, 32'(bus_a.oPCSource), 32'(v.pcs));
            check({v.tag, "/memtoreg"}, 32'(bus_a.oMemtoReg), 32'(v.m2r));
            check({v.tag, "/fault"}, 32'(bus_a.oFault), 32'(v.flt));
            if (v.chk_sel)
                check({v.tag, "/alusel"}, 32'({bus_a.oALUSrcA, bus_a.oALUSrcB, bus_a.oALUOp}),
                      32'(v.sel));
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic do_reset(input int edges);
        iRST_n = 1'b0;
        bus_a.iMemReady = 1'b0;
        bus_a.iMulDone  = 1'b0;
        repeat (edges) @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
    endtask

    task automatic p_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            push("fetch_wait", 1'b0, 1'b0, FETCH, 8'h08, 2'b00, 2'b00, 1'b0, 1'b1, 6'b00_01_00);
        push("fetch", 1'b1, 1'b0, FETCH, 8'h98, 2'b00, 2'b00, 1'b0, 1'b1, 6'b00_01_00);
        push("decode", 1'b1, 1'b0, DECODE, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 6'b10_10_00);
    endtask

    task automatic p_addi(input int waits);
        p_fetch(waits);
        push("exec_i", 1'b1, 1'b0, EXEC_I, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 6'b01_10_10);
        push("aluwb", 1'b1, 1'b0, ALUWB, 8'h02, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
    endtask

    initial begin
        bus_a.iInstruction = 32'h0000_0013;
        bus_a.iZero        = 1'b0;

        // Reset state of both configurations
        do_reset(2);
        check("rst/state_a", 32'(bus_a.oState), 32'(FETCH));
        check("rst/instret_a", 32'(bus_a.oInstret), 32'd0);
        check("rst/fault_a", 32'(bus_a.oFault), 32'd0);
        check("rst/state_b", 32'(bus_b.oState), 32'(FETCH));
        check("rst/fault_b", 32'(bus_b.oFault), 32'd0);

        // addi x1,x0,5
        bus_a.iInstruction = 32'h0050_0093;
        p_addi(0);
        run_queue();
        check("addi/back_to_fetch", 32'(bus_a.oState), 32'(FETCH));
        check("addi/instret", 32'(bus_a.oInstret), 32'd1);

        // lw with three not-ready cycles in MEMREAD
        bus_a.iInstruction = 32'h0000_A103;
        p_fetch(0);
        push("memaddr_lw", 1'b1, 1'b0, MEMADDR, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 6'b01_10_00);
        for (int i = 0; i < 3; i++)
            push("memread_wait", 1'b0, 1'b0, MEMREAD, 8'h28, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
        push("memread", 1'b1, 1'b0, MEMREAD, 8'h28, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
        push("memwb", 1'b1, 1'b0, MEMWB, 8'h02, 2'b00, 2'b01, 1'b0, 1'b0, 6'b0);
        run_queue();
        check("lw/instret", 32'(bus_a.oInstret), 32'd2);

        // sw with two not-ready cycles in MEMWRITE
        bus_a.iInstruction = 32'h0020_A023;
        p_fetch(0);
        push("memaddr_sw", 1'b1, 1'b0, MEMADDR, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 6'b01_10_00);
        for (int i = 0; i < 2; i++)
            push("memwrite_wait", 1'b0, 1'b0, MEMWRITE, 8'h24, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
        push("memwrite", 1'b1, 1'b0, MEMWRITE, 8'h24, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
        run_queue();
        check("sw/instret", 32'(bus_a.oInstret), 32'd3);

        // add x3,x1,x2
        bus_a.iInstruction = 32'h0020_81B3;
        p_fetch(0);
        push("exec_r", 1'b1, 1'b0, EXEC_R, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 6'b01_00_10);
        push("aluwb_r", 1'b1, 1'b0, ALUWB, 8'h02, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
        run_queue();
        check("add/instret", 32'(bus_a.oInstret), 32'd4);

        // beq taken and not taken: same control behaviour either way
        bus_a.iInstruction = 32'h0000_0463;
        for (int z = 1; z >= 0; z--) begin
            bus_a.iZero = z[0];
            p_fetch(0);
            push("branch", 1'b1, 1'b0, BRANCH, 8'h40, 2'b01, 2'b00, 1'b0, 1'b1, 6'b01_00_01);
            run_queue();
        end
        check("beq/instret", 32'(bus_a.oInstret), 32'd6);

        // jal then jalr
        bus_a.iInstruction = 32'h0000_00EF;
        p_fetch(0);
        push("jal", 1'b1, 1'b0, JAL, 8'h82, 2'b01, 2'b10, 1'b0, 1'b0, 6'b0);
        run_queue();
        bus_a.iInstruction = 32'h0000_8067;
        p_fetch(0);
        push("jalr", 1'b1, 1'b0, JALR, 8'h82, 2'b10, 2'b10, 1'b0, 1'b0, 6'b0);
        run_queue();
        check("jump/instret", 32'(bus_a.oInstret), 32'd8);

        // Fetch ready arriving in the last allowed wait cycle
        bus_a.iInstruction = 32'h0050_0093;
        p_addi(14);
        run_queue();
        check("late_ready/instret", 32'(bus_a.oInstret), 32'd9);
        check("late_ready/fault", 32'(bus_a.oFault), 32'd0);

        // mul: accepted with ENABLE_M=1, illegal with ENABLE_M=0
        bus_a.iInstruction = 32'h0220_81B3;
        p_fetch(0);
        push("mul_start", 1'b1, 1'b0, EXEC_M, 8'h01, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
        for (int i = 0; i < 4; i++)
            push("mul_wait", 1'b1, 1'b0, EXEC_M, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
        push("mul_done", 1'b1, 1'b1, EXEC_M, 8'h02, 2'b00, 2'b11, 1'b0, 1'b0, 6'b0);
        run_queue();
        check("mul/instret", 32'(bus_a.oInstret), 32'd10);
        check("mul_disabled/state_b", 32'(bus_b.oState), 32'(HALT));
        check("mul_disabled/fault_b", 32'(bus_b.oFault), 32'd1);
        check("mul_disabled/instret_b", bus_b.oInstret, 32'd9);

        // Illegal opcode 0x7F: HALT held with fault, nothing retired
        bus_a.iInstruction = 32'h0000_007F;
        p_fetch(0);
        for (int i = 0; i < 20; i++)
            push("halt_illegal", 1'b1, 1'b1, HALT, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 6'b0);
        run_queue();
        check("illegal/instret", 32'(bus_a.oInstret), 32'd10);
        do_reset(1);
        check("illegal_rst/state", 32'(bus_a.oState), 32'(FETCH));
        check("illegal_rst/fault", 32'(bus_a.oFault), 32'd0);
        check("illegal_rst/instret", 32'(bus_a.oInstret), 32'd0);
        check("illegal_rst/fault_b", 32'(bus_b.oFault), 32'd0);

        // Unsupported R-type (sll) is illegal
        bus_a.iInstruction = 32'h0020_91B3;
        p_fetch(0);
        push("halt_sll", 1'b1, 1'b0, HALT, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 6'b0);
        push("halt_sll", 1'b1, 1'b0, HALT, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 6'b0);
        run_queue();
        do_reset(1);

        // 16 ALU instructions wrap a 4-bit retire counter
        bus_a.iInstruction = 32'h0050_0093;
        for (int i = 1; i <= 16; i++) begin
            p_addi(0);
            run_queue();
            check("wrap/instret", 32'(bus_a.oInstret), 32'(i % 16));
        end
        check("wrap/instret_b", bus_b.oInstret, 32'd16);

        // Fetch never ready: 15 wait cycles, then HALT with fault
        for (int i = 0; i < 15; i++)
            push("fetch_stall", 1'b0, 1'b0, FETCH, 8'h08, 2'b00, 2'b00, 1'b0, 1'b0, 6'b0);
        push("halt_timeout", 1'b0, 1'b0, HALT, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 6'b0);
        push("halt_timeout", 1'b1, 1'b0, HALT, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 6'b0);
        run_queue();
        check("timeout/instret", 32'(bus_a.oInstret), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
